// File: rtl/d_branch_unit_pkg.sv
// Shared definitions for the D-stage branch unit: opcode encoding, predictor
// counter reset value and index-width helper.
package d_branch_unit_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        B_NONE = 3'd0,
        B_EQ   = 3'd1,
        B_NE   = 3'd2,
        B_LEZ  = 3'd3,
        B_GTZ  = 3'd4,
        B_LTZ  = 3'd5,
        B_GEZ  = 3'd6,
        B_RSVD = 3'd7
    } br_op_e;

    // Weakly-not-taken: MSB clear, every lower bit set (01 for a 2-bit counter).
    function automatic logic [31:0] ctr_rst_val(input int unsigned width);
        logic [31:0] val;
        val = '0;
        for (int unsigned i = 0; i + 1 < width; i++) begin
            val[i] = 1'b1;
        end
        return val;
    endfunction

    function automatic int unsigned idx_w(input int unsigned entries);
        return $clog2(entries);
    endfunction

endpackage

// File: rtl/d_branch_unit_bht_sat_ctr_table.sv
// Table of saturating branch-history counters: one combinational read port
// returning the counter MSB, one synchronous saturating inc/dec write port.
module bht_sat_ctr_table
    import d_branch_unit_pkg::*;
#(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned IDX_W   = idx_w(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_inc
);

    localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(ctr_rst_val(CTR_W));
    localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    logic [CTR_W-1:0] ctr_q [ENTRIES];
    logic [CTR_W-1:0] ctr_d [ENTRIES];

    // No bypass: a same-cycle write is seen by the reader only after the edge.
    assign rd_taken = ctr_q[rd_idx][CTR_W-1];

    always_comb begin
        // NOTE: next-state starts as a copy of the current state so every path assigns it and no latch is inferred.
        ctr_d = ctr_q;
        if (wr_en) begin
            if (wr_inc) begin
                if (ctr_q[wr_idx] != CTR_MAX) begin
                    ctr_d[wr_idx] = ctr_q[wr_idx] + CTR_ONE;
                end
            end else if (ctr_q[wr_idx] != '0) begin
                ctr_d[wr_idx] = ctr_q[wr_idx] - CTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the whole array is reset because the predictor's start state is observable at f_pred_taken; plain data RAMs would skip this.
            ctr_q <= '{default: CTR_RST};
        end else begin
            // NOTE: non-blocking assignment so every flop samples pre-edge values regardless of block ordering.
            ctr_q <= ctr_d;
        end
    end

endmodule

// File: rtl/d_branch_unit.sv
// D-stage branch resolution with a 2-bit-counter BHT, mispredict flag and
// optional resolved/mispredict statistics (enable with `define BRU_STATS_EN).
module d_branch_unit
    import d_branch_unit_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned PC_W        = 32,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned CTR_W       = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   f_pc,
    output logic              f_pred_taken,
    input  logic              d_valid,
    input  logic              d_stall,
    input  logic [PC_W-1:0]   d_pc,
    input  logic [OP_W-1:0]   d_op,
    input  logic [DATA_W-1:0] d_rs,
    input  logic [DATA_W-1:0] d_rt,
    input  logic              d_pred_taken,
    output logic              d_bflag,
    output logic              d_mispredict,
    output logic [31:0]       br_count,
    output logic [31:0]       mis_count
);

    localparam int unsigned IDX_W = idx_w(BHT_ENTRIES);

    logic             is_br;
    logic             update;
    logic             rs_neg;
    logic             rs_zero;
    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] d_idx;

    assign rs_neg  = d_rs[DATA_W-1];
    assign rs_zero = (d_rs == '0);

    always_comb begin
        is_br   = 1'b0;
        d_bflag = 1'b0;
        unique case (br_op_e'(d_op))
            B_EQ:  begin is_br = 1'b1; d_bflag = (d_rs == d_rt);       end
            B_NE:  begin is_br = 1'b1; d_bflag = (d_rs != d_rt);       end
            B_LEZ: begin is_br = 1'b1; d_bflag = rs_neg | rs_zero;     end
            B_GTZ: begin is_br = 1'b1; d_bflag = !rs_neg && !rs_zero;  end
            B_LTZ: begin is_br = 1'b1; d_bflag = rs_neg;               end
            B_GEZ: begin is_br = 1'b1; d_bflag = !rs_neg;              end
            B_NONE, B_RSVD: begin is_br = 1'b0; d_bflag = 1'b0;        end
        endcase
        is_br = is_br & d_valid;
    end

    // Stall qualification is left to pipeline control; only training waits for D to drain.
    assign d_mispredict = is_br && (d_bflag != d_pred_taken);
    assign update       = is_br && !d_stall;

    assign f_idx = f_pc[IDX_W+1:2];
    assign d_idx = d_pc[IDX_W+1:2];

    bht_sat_ctr_table #(
        .ENTRIES (BHT_ENTRIES),
        .CTR_W   (CTR_W),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (f_idx),
        .rd_taken (f_pred_taken),
        .wr_en    (update),
        .wr_idx   (d_idx),
        .wr_inc   (d_bflag)
    );

`ifdef BRU_STATS_EN
    logic [31:0] br_count_d, br_count_q;
    logic [31:0] mis_count_d, mis_count_q;

    always_comb begin
        br_count_d  = br_count_q;
        mis_count_d = mis_count_q;
        if (update) begin
            br_count_d = br_count_q + 32'd1;
            if (d_mispredict) begin
                mis_count_d = mis_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            br_count_q  <= '0;
            mis_count_q <= '0;
        end else begin
            br_count_q  <= br_count_d;
            mis_count_q <= mis_count_d;
        end
    end

    assign br_count  = br_count_q;
    assign mis_count = mis_count_q;
`else
    assign br_count  = '0;
    assign mis_count = '0;
`endif

    logic unused_pc_bits;
    assign unused_pc_bits = ^{f_pc[PC_W-1:IDX_W+2], f_pc[1:0], d_pc[PC_W-1:IDX_W+2], d_pc[1:0]};

endmodule

// File: tb/tb_d_branch_unit.sv
// Directed self-checking bench for d_branch_unit: comparator vector table plus
// hand-written training, stall, collision and statistics sequences.
module tb_d_branch_unit;
    import d_branch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] f_pc;
    logic        f_pred_taken;
    logic        d_valid;
    logic        d_stall;
    logic [31:0] d_pc;
    logic [2:0]  d_op;
    logic [31:0] d_rs;
    logic [31:0] d_rt;
    logic        d_pred_taken;
    logic        d_bflag;
    logic        d_mispredict;
    logic [31:0] br_count;
    logic [31:0] mis_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    d_branch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .f_pc         (f_pc),
        .f_pred_taken (f_pred_taken),
        .d_valid      (d_valid),
        .d_stall      (d_stall),
        .d_pc         (d_pc),
        .d_op         (d_op),
        .d_rs         (d_rs),
        .d_rt         (d_rt),
        .d_pred_taken (d_pred_taken),
        .d_bflag      (d_bflag),
        .d_mispredict (d_mispredict),
        .br_count     (br_count),
        .mis_count    (mis_count)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        valid;
        logic        pred;
        logic        exp_bflag;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_br(input logic [31:0] pc, input logic taken, input logic pred,
                          input logic valid, input logic stall);
        d_pc         = pc;
        d_op         = taken ? 3'(B_EQ) : 3'(B_NE);
        d_rs         = 32'h0000_00AA;
        d_rt         = 32'h0000_00AA;
        d_pred_taken = pred;
        d_valid      = valid;
        d_stall      = stall;
    endtask

    task automatic idle();
        d_valid = 1'b0;
        d_stall = 1'b0;
        d_op    = 3'(B_NONE);
    endtask

    task automatic lookup(input string name, input logic [31:0] pc, input logic expected);
        f_pc = pc;
        #1;
        check(name, 32'(f_pred_taken), 32'(expected));
    endtask

    initial begin
        vecs[0]  = '{3'(B_EQ),  32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{3'(B_NE),  32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{3'(B_LTZ), 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{3'(B_GEZ), 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{3'(B_GTZ), 32'h0000_0000, 32'h0000_0005, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{3'(B_LEZ), 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{3'd7,      32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{3'(B_EQ),  32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{3'(B_NE),  32'h0000_0001, 32'h0000_0003, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{3'(B_GTZ), 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{3'(B_LEZ), 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{3'(B_LTZ), 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{3'(B_GEZ), 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{3'(B_NONE),32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{3'(B_EQ),  32'h0000_0042, 32'h0000_0042, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{3'(B_LEZ), 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1};

        reset = 1'b0;
        f_pc  = 32'h3000;
        d_pc  = 32'h0;
        d_rs  = 32'h0;
        d_rt  = 32'h0;
        d_pred_taken = 1'b0;
        idle();
        repeat (2) tick();
        reset = 1'b1;

        // Reset then lookup
        lookup("rst_pred_3000", 32'h3000, 1'b0);
        lookup("rst_pred_3004", 32'h3004, 1'b0);
        lookup("rst_pred_30fc", 32'h30FC, 1'b0);
        check("rst_br_count", br_count, 32'd0);
        check("rst_mis_count", mis_count, 32'd0);

        // Comparator sweep, held in stall so nothing trains
        for (int i = 0; i < 16; i++) begin
            d_pc         = 32'h3100;
            d_op         = vecs[i].op;
            d_rs         = vecs[i].rs;
            d_rt         = vecs[i].rt;
            d_valid      = vecs[i].valid;
            d_pred_taken = vecs[i].pred;
            d_stall      = 1'b1;
            #1;
            check($sformatf("vec%0d_bflag", i), 32'(d_bflag), 32'(vecs[i].exp_bflag));
            check($sformatf("vec%0d_mispredict", i), 32'(d_mispredict), 32'(vecs[i].exp_mis));
            tick();
        end
        idle();
        lookup("sweep_no_train", 32'h3100, 1'b0);

        // Training at 0x3010: 01 -> 10 -> 11 -> 11 -> 10 -> 01
        f_pc = 32'h3010;
        set_br(32'h3010, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        check("train_mispredict", 32'(d_mispredict), 32'd1);
        check("train_pre_pred", 32'(f_pred_taken), 32'd0);
        tick();
        idle();
        lookup("train_after_1_taken", 32'h3010, 1'b1);
        set_br(32'h3010, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        check("train_no_mispredict", 32'(d_mispredict), 32'd0);
        repeat (2) tick();
        idle();
        lookup("train_saturated", 32'h3010, 1'b1);
        set_br(32'h3010, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        lookup("train_after_1_not_taken", 32'h3010, 1'b1);
        set_br(32'h3010, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        lookup("train_after_2_not_taken", 32'h3010, 1'b0);

        // Stall: three held cycles then release trains exactly once
        f_pc = 32'h3020;
        set_br(32'h3020, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (3) begin
            #1;
            check("stall_mispredict_held", 32'(d_mispredict), 32'd1);
            tick();
        end
        lookup("stall_no_train_yet", 32'h3020, 1'b0);
        d_stall = 1'b0;
        tick();
        idle();
        lookup("stall_released", 32'h3020, 1'b1);
        set_br(32'h3020, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        lookup("stall_single_increment", 32'h3020, 1'b0);

        // Bubble: invalid branch neither flags nor trains
        set_br(32'h3020, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("bubble_mispredict", 32'(d_mispredict), 32'd0);
        tick();
        idle();
        lookup("bubble_no_train", 32'h3020, 1'b0);

        // Collision: read shows pre-update value, new value the next cycle
        f_pc = 32'h3040;
        set_br(32'h3040, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        check("collide_same_cycle", 32'(f_pred_taken), 32'd0);
        tick();
        idle();
        #1;
        check("collide_next_cycle", 32'(f_pred_taken), 32'd1);

        // Statistics: clean slate, 5 taken branches at 0x3080, 2 mispredicted
        reset = 1'b0;
        tick();
        reset = 1'b1;
        lookup("stats_rst_pred_3010", 32'h3010, 1'b0);
        for (int i = 0; i < 5; i++) begin
            set_br(32'h3080, 1'b1, (i == 1 || i == 3) ? 1'b0 : 1'b1, 1'b1, 1'b0);
            tick();
        end
        idle();
        lookup("stats_pred_trained", 32'h3080, 1'b1);
`ifdef BRU_STATS_EN
        check("stats_br_count", br_count, 32'd5);
        check("stats_mis_count", mis_count, 32'd2);
`else
        check("stats_br_count_tied", br_count, 32'd0);
        check("stats_mis_count_tied", mis_count, 32'd0);
`endif
        // Reset mid-sequence wins over a concurrent update
        set_br(32'h3080, 1'b1, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        check("rst_comb_bflag", 32'(d_bflag), 32'd1);
        tick();
        reset = 1'b1;
        idle();
        check("midrst_br_count", br_count, 32'd0);
        check("midrst_mis_count", mis_count, 32'd0);
        lookup("midrst_pred_3080", 32'h3080, 1'b0);
        set_br(32'h3080, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        lookup("midrst_entry_is_01", 32'h3080, 1'b1);
`ifdef BRU_STATS_EN
        check("post_rst_br_count", br_count, 32'd1);
        check("post_rst_mis_count", mis_count, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/d_branch_unit.md
Name: d_branch_unit

Overview:
- Parametrised successor to the single-mode D-stage branch comparator.
- Resolves all MIPS conditional branch types in the D stage.
- Holds a BHT of 2-bit saturating counters. The F stage looks it up, and resolved D-stage branches train it.
- Flags a mispredict so the pipeline control can redirect F and flush the wrong-path instruction.

Parameters:
- DATA_W, 32, operand width of rs/rt.
- PC_W, 32, PC width.
- BHT_ENTRIES, 64, number of predictor entries; must be a power of 2, minimum 2.
- CTR_W, 2, saturating counter width; must be at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low (reset==0 on a rising clk edge resets the block).
- f_pc  input  PC_W  F-stage PC for prediction lookup.
- f_pred_taken  output  1  prediction for f_pc.
- d_valid  input  1  D-stage instruction is valid (not a bubble).
- d_stall  input  1  D stage held this cycle.
- d_pc  input  PC_W  PC of the D-stage instruction.
- d_op  input  3  branch opcode (package encoding).
- d_rs  input  DATA_W  forwarded rs value.
- d_rt  input  DATA_W  forwarded rt value.
- d_pred_taken  input  1  prediction piped from F with the instruction.
- d_bflag  output  1  branch condition true.
- d_mispredict  output  1  resolved outcome differs from prediction.
- br_count  output  32  resolved-branch counter (optional feature).
- mis_count  output  32  mispredict counter (optional feature).

Behaviour:
- d_op encoding:
  - B_NONE=0, B_EQ=1, B_NE=2, B_LEZ=3, B_GTZ=4, B_LTZ=5, B_GEZ=6.
  - 7 is reserved and treated as B_NONE.
- Conditions:
  - EQ/NE compare rs and rt over the full DATA_W bits.
  - LEZ/GTZ/LTZ/GEZ compare rs signed against 0; rt is ignored.
- d_bflag: combinational; 1 only when d_op is a branch type and its condition holds; 0 for B_NONE/reserved.
- is_br = d_valid and d_op in 1..6.
- d_mispredict: combinational, = is_br and (d_bflag != d_pred_taken). It is not gated by d_stall; control qualifies it.
- Index: idx(pc) = pc[log2(BHT_ENTRIES)+1 : 2]. Word-aligned PCs; bits [1:0] are ignored.
- f_pred_taken = MSB of ctr[idx(f_pc)]. This is a combinational read.
- Update, on the rising edge when reset==1, is_br==1 and d_stall==0:
  - ctr[idx(d_pc)] increments, saturating at all-ones, if d_bflag==1.
  - Otherwise it decrements, saturating at 0.
  - At most one entry is written per cycle.
- Read/write collision on the same index in the same cycle: f_pred_taken shows the pre-update value. The new value is visible the next cycle; there is no bypass.
- Aliasing between PCs sharing an index is accepted; there are no tags.
- Reset (reset==0 at an edge):
  - Every ctr entry = weakly-not-taken (MSB 0, all other bits 1; 01 for CTR_W=2).
  - br_count = 0, mis_count = 0.
  - Reset has priority over a concurrent update.
  - Combinational outputs track their inputs during reset. f_pred_taken reads the entry's current contents, which equal the reset value from the edge after reset is first sampled.
- A stalled branch (d_stall==1) is evaluated every cycle but trains the table once, on the cycle it leaves D.

Optional Feature:
- Macro: BRU_STATS_EN.
- Defined:
  - br_count += 1 per update event.
  - mis_count += 1 per update event with d_mispredict==1.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and are cleared by reset.
- Undefined:
  - Ports remain present, tied to 0.
  - No counter flops are synthesised.

Decomposition:
- Shared package/define file holds:
  - d_op encodings B_NONE..B_GEZ.
  - CTR reset-value constant.
  - idx-width helper (clog2).
- Sub-module bht_sat_ctr_table, which holds:
  - the counter array;
  - one combinational read port;
  - one synchronous write port with saturating increment/decrement;
  - synchronous active-low reset.
- The comparator, mispredict logic and stats stay in the top module.

Test Plan:
- Reset then lookup:
  - Stimulus: reset=0 for 2 cycles, then f_pc=0x3000, 0x3004, 0x30FC.
  - Required: f_pred_taken=0 for every address; br_count=mis_count=0.
- Comparator sweep:
  - EQ, rs=rt=0x12345678 → d_bflag=1.
  - NE, same operands → d_bflag=0.
  - LTZ, rs=0x80000000 → 1.
  - GEZ, rs=0 → 1.
  - GTZ, rs=0 → 0.
  - LEZ, rs=0xFFFFFFFF → 1.
  - op=7 → 0.
- Training:
  - Stimulus: d_pc=0x3010, BEQ taken, d_pred_taken=0, d_stall=0.
  - After 1 update: d_mispredict=1 during resolve; f_pc=0x3010 next cycle → f_pred_taken=1 (ctr 10).
  - After 2 more taken updates: ctr stays at 11.
  - After 1 not-taken update: still predicts 1.
  - After a 2nd not-taken update: predicts 0.
- Stall and bubble:
  - Taken branch at 0x3020 held with d_stall=1 for 3 cycles, then released: exactly one increment (f_pred_taken=1 after 1 update).
  - Same branch with d_valid=0: no update, d_mispredict=0.
- Collision:
  - Stimulus: f_pc=d_pc=0x3040 in the same cycle, taken update from 01.
  - Required: f_pred_taken=0 that cycle and 1 the next.
- Stats (BRU_STATS_EN):
  - 5 resolved branches, 2 mispredicted → br_count=5, mis_count=2.
  - Reset mid-sequence → both 0 on the next cycle, and the BHT entry returns to 01.
